// File: rtl/lbist_pkg.sv
// Shared LBIST definitions: sequencer state encoding and small decode helpers,
// reused by the controller and by status/debug readout logic.
package lbist_pkg;

  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE    = 3'd0,
    S_INIT    = 3'd1,
    S_SHIFT   = 3'd2,
    S_CAPTURE = 3'd3,
    S_COMPARE = 3'd4,
    S_DONE    = 3'd5
  } lbist_state_e;

  // A run is in progress from INIT through COMPARE.
  function automatic logic is_busy(input lbist_state_e s);
    return (s == S_INIT) || (s == S_SHIFT) || (s == S_CAPTURE) || (s == S_COMPARE);
  endfunction

endpackage

// File: rtl/lbist_cnt.sv
// Modulo-MOD wrap counter with synchronous clear (priority over enable)
// and a terminal-count flag that is high while the count equals MOD-1.
module lbist_cnt #(
  parameter int unsigned MOD = 4,
  parameter int unsigned W   = $clog2(MOD)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o,
  output logic         tc_o
);

  localparam logic [W-1:0] LAST = W'(MOD - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign tc_o  = (cnt_q == LAST);
  assign cnt_o = cnt_q;

  // Next count: clear wins, otherwise advance and wrap after the terminal value.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tc_o ? '0 : cnt_q + W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/lbist_ctrl.sv
// Logic-BIST sequencer: seed -> (shift, capture) x N_PATTERNS -> unload -> compare.
// Every output is a register loaded from the next state, so nothing on the
// output side depends combinationally on start/abort/sig.
module lbist_ctrl
  import lbist_pkg::*;
#(
  parameter int unsigned     SCAN_LEN   = 64,
  parameter int unsigned     N_PATTERNS = 1024,
  parameter int unsigned     SIG_W      = 24,
  parameter logic [SIG_W-1:0] GOLDEN    = '0
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  input  logic                              abort,
  input  logic [SIG_W-1:0]                  sig,
  output logic                              tpg_clr,
  output logic                              tpg_en,
  output logic                              misr_clr,
  output logic                              misr_en,
  output logic                              scan_en,
  output logic                              capture,
  output logic                              busy,
  output logic                              done,
  output logic                              pass,
  output logic [$clog2(N_PATTERNS+1)-1:0]   pat_cnt
);

  localparam int unsigned SH_W = $clog2(SCAN_LEN);
  localparam int unsigned PC_W = $clog2(N_PATTERNS + 1);

  lbist_state_e state_q, state_d;
  logic         first_q, first_d;
  logic         pass_d;
  logic         tpg_clr_q, tpg_en_q, misr_clr_q, misr_en_q;
  logic         scan_en_q, capture_q, busy_q, done_q, pass_q;

  logic [SH_W-1:0] sh_cnt_unused;
  logic            sh_tc;
  logic [PC_W-1:0] pc_cnt;
  logic            pc_tc;
  logic            cnt_clr;

  // Both counters restart whenever a run begins or the sequencer falls back to IDLE.
  assign cnt_clr = (state_d == S_INIT) || (state_d == S_IDLE);

  lbist_cnt #(.MOD(SCAN_LEN), .W(SH_W)) u_shift_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (cnt_clr),
    .en_i  (state_q == S_SHIFT),
    .cnt_o (sh_cnt_unused),
    .tc_o  (sh_tc)
  );

  // Pattern count spans 0..N_PATTERNS; the terminal value doubles as "all captures done"
  // and the enable is gated there so the count saturates instead of wrapping.
  lbist_cnt #(.MOD(N_PATTERNS + 1), .W(PC_W)) u_pat_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (cnt_clr),
    .en_i  ((state_q == S_CAPTURE) && !pc_tc),
    .cnt_o (pc_cnt),
    .tc_o  (pc_tc)
  );

  // Next state, first-shift flag and pass result; abort beats every other request.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (start && !abort) state_d = S_INIT;
      S_INIT:    state_d = abort ? S_IDLE : S_SHIFT;
      S_SHIFT:   if (abort)      state_d = S_IDLE;
                 else if (sh_tc) state_d = pc_tc ? S_COMPARE : S_CAPTURE;
      S_CAPTURE: state_d = abort ? S_IDLE : S_SHIFT;
      S_COMPARE: state_d = abort ? S_IDLE : S_DONE;
      S_DONE:    if (abort)      state_d = S_IDLE;
                 else if (start) state_d = S_INIT;
      default:   state_d = S_IDLE;
    endcase

    // The first shift pass only loads the chains; nothing valid to compact yet.
    first_d = first_q;
    if (state_d == S_INIT) begin
      first_d = 1'b1;
    end else if ((state_q == S_SHIFT) && sh_tc) begin
      first_d = 1'b0;
    end

    pass_d = 1'b0;
    if (state_d == S_DONE) begin
      pass_d = (state_q == S_COMPARE) ? (sig == GOLDEN) : pass_q;
    end
  end

  // State register with outputs decoded from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      first_q    <= 1'b0;
      tpg_clr_q  <= 1'b0;
      tpg_en_q   <= 1'b0;
      misr_clr_q <= 1'b0;
      misr_en_q  <= 1'b0;
      scan_en_q  <= 1'b0;
      capture_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      first_q    <= first_d;
      tpg_clr_q  <= (state_d == S_INIT);
      misr_clr_q <= (state_d == S_INIT);
      tpg_en_q   <= (state_d == S_SHIFT);
      scan_en_q  <= (state_d == S_SHIFT);
      misr_en_q  <= (state_d == S_SHIFT) && !first_d;
      capture_q  <= (state_d == S_CAPTURE);
      busy_q     <= is_busy(state_d);
      done_q     <= (state_d == S_DONE);
      pass_q     <= pass_d;
    end
  end

  assign tpg_clr  = tpg_clr_q;
  assign tpg_en   = tpg_en_q;
  assign misr_clr = misr_clr_q;
  assign misr_en  = misr_en_q;
  assign scan_en  = scan_en_q;
  assign capture  = capture_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign pat_cnt  = pc_cnt;

endmodule

// File: tb/tb_lbist_ctrl.sv
// Bench for lbist_ctrl: two instances (N_PATTERNS=3 and N_PATTERNS=1, SCAN_LEN=4),
// per-cycle comparison against a run-timeline model derived from cycle arithmetic.
module tb_lbist_ctrl;

  localparam int          SL     = 4;
  localparam logic [23:0] GOLDEN = 24'h5A3C96;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        start0, abort0, start1, abort1;
  logic [23:0] sig0, sig1;
  logic tpg_clr0, tpg_en0, misr_clr0, misr_en0, scan_en0, capture0, busy0, done0, pass0;
  logic tpg_clr1, tpg_en1, misr_clr1, misr_en1, scan_en1, capture1, busy1, done1, pass1;
  logic [1:0] pat0;
  logic [0:0] pat1;

  lbist_ctrl #(.SCAN_LEN(SL), .N_PATTERNS(3), .SIG_W(24), .GOLDEN(GOLDEN)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0), .sig(sig0),
    .tpg_clr(tpg_clr0), .tpg_en(tpg_en0), .misr_clr(misr_clr0), .misr_en(misr_en0),
    .scan_en(scan_en0), .capture(capture0), .busy(busy0), .done(done0), .pass(pass0),
    .pat_cnt(pat0)
  );

  lbist_ctrl #(.SCAN_LEN(SL), .N_PATTERNS(1), .SIG_W(24), .GOLDEN(GOLDEN)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .sig(sig1),
    .tpg_clr(tpg_clr1), .tpg_en(tpg_en1), .misr_clr(misr_clr1), .misr_en(misr_en1),
    .scan_en(scan_en1), .capture(capture1), .busy(busy1), .done(done1), .pass(pass1),
    .pat_cnt(pat1)
  );

  // {tpg_clr, tpg_en, misr_clr, misr_en, scan_en, capture, busy, done, pass}
  logic [8:0] obs0, obs1;
  assign obs0 = {tpg_clr0, tpg_en0, misr_clr0, misr_en0, scan_en0, capture0, busy0, done0, pass0};
  assign obs1 = {tpg_clr1, tpg_en1, misr_clr1, misr_en1, scan_en1, capture1, busy1, done1, pass1};

  int n_checks = 0;
  int n_fail   = 0;
  int run_id   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected outputs k cycles after INIT entry: INIT, then (N+1) shift passes of SL
  // cycles interleaved with N single captures, one compare cycle, then DONE.
  function automatic logic [8:0] model_out(input int k, input int np, input bit expp);
    int tsc, j, blk, off;
    logic [8:0] o;
    o   = '0;
    tsc = (np + 1) * SL + np;
    if (k == 0) begin
      o[8] = 1'b1; o[6] = 1'b1; o[2] = 1'b1;
    end else begin
      j = k - 1;
      if (j < tsc) begin
        blk = j / (SL + 1);
        off = j % (SL + 1);
        if (off < SL) begin
          o[7] = 1'b1; o[4] = 1'b1; o[2] = 1'b1; o[5] = (blk > 0);
        end else begin
          o[3] = 1'b1; o[2] = 1'b1;
        end
      end else if (j == tsc) begin
        o[2] = 1'b1;
      end else begin
        o[1] = 1'b1; o[0] = expp;
      end
    end
    return o;
  endfunction

  function automatic int model_pc(input int k, input int np);
    int tsc;
    tsc = (np + 1) * SL + np;
    if (k == 0) return 0;
    if (k - 1 < tsc) return (k - 1) / (SL + 1);
    return np;
  endfunction

  task automatic drive(input bit sel, input logic st, input logic ab, input logic [23:0] sg);
    if (sel) begin start1 = st; abort1 = ab; sig1 = sg; end
    else     begin start0 = st; abort0 = ab; sig0 = sg; end
  endtask

  task automatic sample(input bit sel, output logic [31:0] o, output logic [31:0] pc);
    o  = sel ? {23'd0, obs1} : {23'd0, obs0};
    pc = sel ? {31'd0, pat1} : {30'd0, pat0};
  endtask

  task automatic chk_idle(input bit sel, input string tag);
    logic [31:0] o, pc;
    sample(sel, o, pc);
    chk({tag, " outs"}, o, 32'd0);
    chk({tag, " pat_cnt"}, pc, 32'd0);
  endtask

  // One run from IDLE/DONE. abort_k / rst_k >= 0 cut the run at that cycle index.
  task automatic run(input bit sel, input logic [23:0] sv, input int abort_k,
                     input bit stray, input int rst_k);
    int np, last;
    bit expp;
    logic [31:0] o, pc;
    run_id++;
    np   = sel ? 1 : 3;
    last = (np + 1) * SL + np + 2;
    expp = (sv == GOLDEN);
    drive(sel, 1'b1, 1'b0, 24'($urandom));
    @(negedge clk);
    for (int k = 0; k <= last; k++) begin
      sample(sel, o, pc);
      chk($sformatf("run%0d k%0d outs", run_id, k), o, {23'd0, model_out(k, np, expp)});
      if (k != 0)
        chk($sformatf("run%0d k%0d pat_cnt", run_id, k), pc, 32'(model_pc(k, np)));
      if (k == rst_k) begin
        #2 rst_n = 1'b0;
        #1 chk_idle(sel, $sformatf("run%0d async_rst", run_id));
        drive(sel, 1'b0, 1'b0, '0);
        @(negedge clk);
        rst_n = 1'b1;
        chk_idle(sel, $sformatf("run%0d after_rst", run_id));
        return;
      end
      if (k == abort_k) begin
        drive(sel, stray ? 1'($urandom) : 1'b0, 1'b1, 24'($urandom));
        @(negedge clk);
        drive(sel, 1'b0, 1'b0, '0);
        chk_idle(sel, $sformatf("run%0d abort_k%0d", run_id, k));
        return;
      end
      if (k < last) begin
        drive(sel, (stray ? 1'($urandom) : 1'b0), 1'b0,
              (k == last - 1) ? sv : 24'($urandom));
        @(negedge clk);
      end else begin
        drive(sel, 1'b0, 1'b0, 24'($urandom));
      end
    end
  endtask

  task automatic hold_done(input bit sel, input int n, input bit expp);
    logic [31:0] o, pc;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      sample(sel, o, pc);
      chk($sformatf("run%0d hold%0d outs", run_id, i), o, {30'd0, 1'b1, expp});
      chk($sformatf("run%0d hold%0d pat_cnt", run_id, i), pc, sel ? 32'd1 : 32'd3);
    end
  endtask

  initial begin
    logic [23:0] sv;
    int          ak;
    rst_n = 1'b0;
    drive(0, 1'b0, 1'b0, '0);
    drive(1, 1'b0, 1'b0, '0);
    repeat (3) @(negedge clk);
    chk_idle(0, "reset0");
    chk_idle(1, "reset1");
    rst_n = 1'b1;
    @(negedge clk);
    chk_idle(0, "post_reset0");

    // Golden signature, then a one-bit-off signature; pass must hold in DONE.
    run(0, GOLDEN, -1, 1'b0, -1);
    hold_done(0, 3, 1'b1);
    run(0, GOLDEN ^ 24'h1, -1, 1'b0, -1);
    hold_done(0, 3, 1'b0);

    // Abort on the second cycle of the second shift pass (k=7).
    run(0, GOLDEN, 7, 1'b0, -1);

    // start together with abort in IDLE: stays IDLE.
    drive(0, 1'b1, 1'b1, '0);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, '0);
    chk_idle(0, "start_abort_idle");

    // Clean run with stray starts while busy, then start+abort in DONE -> IDLE.
    run(0, GOLDEN, -1, 1'b1, -1);
    drive(0, 1'b1, 1'b1, '0);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, '0);
    chk_idle(0, "start_abort_done");

    // Failing run, then plain abort in DONE -> IDLE.
    run(0, GOLDEN ^ 24'h800000, -1, 1'b1, -1);
    drive(0, 1'b0, 1'b1, '0);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, '0);
    chk_idle(0, "abort_done");

    // Randomized runs: signatures, idle gaps, stray starts, abort points.
    for (int r = 0; r < 12; r++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      sv = ($urandom % 2) ? GOLDEN : 24'($urandom);
      ak = (($urandom % 4) == 0) ? int'($urandom_range(0, 20)) : -1;
      run(0, sv, ak, 1'b1, -1);
    end

    // Asynchronous reset during the first capture cycle (k=5).
    run(0, GOLDEN, -1, 1'b0, 5);
    run(0, GOLDEN, -1, 1'b0, -1);

    // Single-pattern instance: DONE 11 cycles after INIT entry.
    run(1, GOLDEN, -1, 1'b0, -1);
    hold_done(1, 2, 1'b1);
    run(1, 24'($urandom), -1, 1'b1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
